// File: rtl/chess_io_pkg.sv
// Shared types and default timing for the DE2 board-input conditioner.
//   dbnc_state_t : per-key debounce channel state
//   CLK_HZ, DEBOUNCE_MS : board clock and debounce window used to derive the
//                         default DEBOUNCE_CYCLES
//   key_level_of() : debounced level implied by a channel state
package chess_io_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_WT = 2'd1,
        HELD     = 2'd2,
        REL_WT   = 2'd3
    } dbnc_state_t;

    localparam int CLK_HZ                  = 50_000_000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEFAULT_REPEAT_DELAY    = 25_000_000;
    localparam int DEFAULT_REPEAT_PERIOD   = 5_000_000;

    // A key counts as held from acceptance until its release is accepted, so a
    // release bounce (REL_WT) keeps the level high.
    function automatic logic key_level_of(input dbnc_state_t st);
        return (st == HELD) || (st == REL_WT);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM and timers.
// Optional auto-repeat while held is built when AUTO_REPEAT_EN is defined.
// Ports:
//   clk_sys     in   system clock
//   rst_b       in   asynchronous active-low reset
//   key_n       in   raw pushbutton, 0 = pressed, asynchronous
//   key_level   out  debounced pressed level
//   key_press   out  one-cycle pulse on accepted press / auto-repeat
//   key_release out  one-cycle pulse on accepted release
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | key released and stable
// PRESS_WT | key seen pressed, counting stable cycles before accepting
// HELD     | press accepted, key_level = 1 (auto-repeat timer runs here)
// REL_WT   | key seen released, counting stable cycles before accepting
module key_debounce_ch
    import chess_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    dbnc_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             act;

`ifdef AUTO_REPEAT_EN
    localparam int               RCNT_W      = $clog2(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RCNT_LAST   = RCNT_W'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD makes the next terminal count PERIOD cycles away.
    localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
`endif

    assign act = ~sync2_q;

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt_d    = rcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d = PRESS_WT;
                    cnt_d   = '0;
                end
            end
            PRESS_WT: begin
                if (!act) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rcnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!act) begin
                    state_d = REL_WT;
                    cnt_d   = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (rcnt_q == RCNT_LAST) begin
                    press_d = 1'b1;
                    rcnt_d  = RCNT_RELOAD;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
`endif
            end
            REL_WT: begin
                // rcnt is left frozen here; only a return to HELD clears it.
                if (act) begin
                    state_d = HELD;
                    cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
                    rcnt_d  = '0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef AUTO_REPEAT_EN
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    assign key_level   = key_level_of(state_q);
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/chess_input_ctrl.sv
// Board-input conditioner between the DE2 pins and the chess core: one
// debounce channel per pushbutton plus a 2-flop synchroniser per switch.
// Define AUTO_REPEAT_EN to enable auto-repeat press pulses while a key is held.
// Ports:
//   CLOCK_50    in   system clock, sole clock domain
//   reset_n     in   asynchronous active-low reset
//   key_n       in   raw pushbuttons, 0 = pressed
//   sw_raw      in   raw slide switches
//   key_level   out  debounced pressed level per key
//   key_press   out  one-cycle press (and repeat) pulse per key
//   key_release out  one-cycle release pulse per key
//   sw_sync     out  synchronised switch levels
module chess_input_ctrl
    import chess_io_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int NUM_SW          = 18,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_SW-1:0]   sw_sync
);

    logic [NUM_SW-1:0] sw_meta_q, sw_meta_d;
    logic [NUM_SW-1:0] sw_sync_q, sw_sync_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_sys     (CLOCK_50),
            .rst_b       (reset_n),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

    always_comb begin
        sw_meta_d = sw_raw;
        sw_sync_d = sw_meta_q;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign sw_sync = sw_sync_q;

endmodule

// File: tb/tb_chess_input_ctrl.sv
// Scoreboard bench for chess_input_ctrl with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Stimulus pushes expected pulse events
// (cycle, press vector, release vector); a negedge monitor pops and compares
// whenever the DUT shows a pulse and flags pulses that never arrived.
module tb_chess_input_ctrl;

    localparam int NK = 3;
    localparam int NS = 18;
    localparam int LAT = 7;   // drive cycle -> pulse visible at negedge

    logic          clk;
    logic          reset_n;
    logic [NK-1:0] key_n;
    logic [NS-1:0] sw_raw;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NS-1:0] sw_sync;

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    chess_input_ctrl #(
        .NUM_KEYS        (NK),
        .NUM_SW          (NS),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .CLOCK_50    (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .sw_raw      (sw_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_sync     (sw_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every observed pulse against the scoreboard head.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL missed_pulse cyc=%0d: no pulse observed, required press=%b release=%b at cyc %0d",
                     cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (key_press != '0 || key_release != '0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse cyc=%0d: got press=%b release=%b, required none",
                         cyc, key_press, key_release);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release) begin
                    n_errors++;
                    $display("FAIL pulse: got cyc=%0d press=%b release=%b, required cyc=%0d press=%b release=%b",
                             cyc, key_press, key_release, e.cyc, e.press, e.rel);
                end
            end
        end
    end

    task automatic nedges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %h, required %h", name, cyc, got, req);
        end
    endtask

    task automatic push(input int c, input logic [NK-1:0] p, input logic [NK-1:0] r);
        exp_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    int c;
    int d;
    int f;
    int r;

    initial begin
        reset_n = 1'b0;
        key_n   = '1;
        sw_raw  = '0;
        nedges(2);
        chk("reset_level",   32'(key_level),   32'h0);
        chk("reset_press",   32'(key_press),   32'h0);
        chk("reset_release", 32'(key_release), 32'h0);
        chk("reset_sw",      32'(sw_sync),     32'h0);
        reset_n = 1'b1;
        nedges(3);

        // Clean press and release on key 0, held long enough for repeats.
        c = cyc;
        key_n[0] = 1'b0;
        push(c + LAT, 3'b001, 3'b000);
`ifdef AUTO_REPEAT_EN
        for (int t = c + LAT + 10; t <= c + 24; t += 3) push(t, 3'b001, 3'b000);
`endif
        nedges(10);
        chk("press_level", 32'(key_level), 32'h1);
        nedges(12);
        key_n[0] = 1'b1;
        push(c + 22 + LAT, 3'b000, 3'b001);
        nedges(6);
        chk("rel_wait_level", 32'(key_level), 32'h1);
        nedges(2);
        chk("released_level", 32'(key_level), 32'h0);

        // Glitch on key 1: three low samples is too short to accept.
        nedges(3);
        key_n[1] = 1'b0;
        nedges(3);
        key_n[1] = 1'b1;
        nedges(10);
        chk("glitch_level", 32'(key_level), 32'h0);

        // Release bounce on key 0.
        c = cyc;
        key_n[0] = 1'b0;
        push(c + LAT, 3'b001, 3'b000);
        nedges(9);
        d = cyc;
        key_n[0] = 1'b1;
        nedges(2);
        key_n[0] = 1'b0;
        nedges(2);
        key_n[0] = 1'b1;
        f = cyc;
        push(f + LAT, 3'b000, 3'b001);
        nedges(6);
        chk("bounce_level_hold", 32'(key_level), 32'h1);
        nedges(2);
        chk("bounce_level_rel", 32'(key_level), 32'h0);

        // Simultaneous press/release on all keys.
        nedges(2);
        c = cyc;
        key_n = 3'b000;
        push(c + LAT, 3'b111, 3'b000);
        nedges(8);
        chk("simul_level", 32'(key_level), 32'h7);
        nedges(1);
        key_n = 3'b111;
        push(c + 9 + LAT, 3'b000, 3'b111);
        nedges(8);
        chk("simul_rel_level", 32'(key_level), 32'h0);

        // Switch synchroniser: two-edge latency.
        sw_raw = 18'h20A5A;
        nedges(1);
        chk("sw_one_edge", 32'(sw_sync), 32'h0);
        nedges(1);
        chk("sw_two_edges", 32'(sw_sync), 32'h20A5A);
        sw_raw = 18'h1F0F0;
        nedges(2);
        chk("sw_toggle", 32'(sw_sync), 32'h1F0F0);

        // Reset with key 0 held and key 1 mid-debounce.
        c = cyc;
        key_n[0] = 1'b0;
        push(c + LAT, 3'b001, 3'b000);
        nedges(9);
        chk("pre_reset_level", 32'(key_level), 32'h1);
        key_n[1] = 1'b0;
        nedges(4);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_level",   32'(key_level),   32'h0);
        chk("async_rst_press",   32'(key_press),   32'h0);
        chk("async_rst_release", 32'(key_release), 32'h0);
        chk("async_rst_sw",      32'(sw_sync),     32'h0);
        nedges(2);
        reset_n = 1'b1;
        r = cyc;
        push(r + LAT, 3'b011, 3'b000);
        nedges(9);
        key_n = 3'b111;
        push(r + 9 + LAT, 3'b000, 3'b011);
        nedges(10);
        chk("post_reset_level", 32'(key_level), 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
